psx_poll_sequencer: RTL and testbench
=====================================

Name: psx_poll_sequencer

Overview:
- Host-side frame scheduler for the PSX controller bus.
- Periodically lowers att and sequences the standard 5-byte poll (0x01, 0x42, 0x00, 0x00, 0x00) through a byte-level transceiver that owns psx_clk/cmd/dat.
- Waits for the controller's ack_n between bytes and captures the controller ID and the 16-bit button word.
- Aborts cleanly on a missing ack, a bad 0x5A marker, or a transceiver stall.

Parameters:
- POLL_PERIOD, 32'd33333: idle cycles between frames, counted from att high to next att low (16.67 ms at 500 ns/cycle).
- ATT_SETUP, 8'd40: cycles att is held low before first xfer_start (20 us).
- ACK_TIMEOUT, 16'd200: maximum cycles from xfer_done to ack seen (100 us).
- INTER_BYTE, 8'd8: cycles from ack seen to next xfer_start.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  level; allows new frames to start
- ack_n  input  1  controller ack, asynchronous, active low
- xfer_start  output  1  one-cycle pulse; transceiver begins shifting xfer_tx
- xfer_tx  output  8  byte to send; valid on the xfer_start cycle
- xfer_done  input  1  one-cycle pulse; byte shifted, xfer_rx valid this cycle
- xfer_rx  input  8  byte received from controller
- att  output  1  attention, active low
- ctrl_id  output  8  last good ID byte
- buttons  output  16  last good button word, {byte4, byte3}, active low as on wire
- frame_valid  output  1  one-cycle pulse after a good frame
- err  output  1  one-cycle pulse on aborted frame
- err_code  output  2  01 ack timeout, 10 bad marker, 11 transceiver stall; held until next err
- busy  output  1  high from att low through att high

Behaviour:
- Reset (async, rst_n low):
  - Outputs: att=1, xfer_start=0, xfer_tx=8'hFF, ctrl_id=8'hFF, buttons=16'hFFFF, frame_valid=0, err=0, err_code=0, busy=0.
  - State IDLE, all counters 0.
  - Mid-frame reset raises att immediately, without waiting for clk.
- ack_n passes a 2-flop synchronizer; ack_seen = synchronized falling edge.
- A sticky ack flag is cleared on each xfer_start and set by ack_seen, so an ack arriving before xfer_done still counts.
- States and transitions:
  - IDLE: if enable, go to WAIT_PERIOD with the counter at 0.
  - WAIT_PERIOD:
    - Counter increments each cycle.
    - When it reaches POLL_PERIOD-1 and enable=1: att<=0, busy<=1, byte index<=0, go to ATT_SETUP.
    - If enable=0: return to IDLE.
  - ATT_SETUP: after ATT_SETUP cycles, go to SEND.
  - SEND: xfer_start=1 for exactly one cycle; xfer_tx = table[index]; go to XFER.
  - XFER:
    - Wait for xfer_done.
    - Capture per index: 1 -> id_tmp, 2 -> must equal 8'h5A, 3 -> btn_lo, 4 -> btn_hi.
    - If index 2 does not equal 8'h5A: abort with code 10.
    - If no xfer_done within 4*ACK_TIMEOUT cycles: abort with code 11.
    - On xfer_done: index 4 goes to DONE; otherwise go to WAIT_ACK.
  - WAIT_ACK:
    - Ack flag set: go to GAP.
    - ACK_TIMEOUT cycles elapsed since xfer_done without ack: abort with code 01.
  - GAP: after INTER_BYTE cycles, index++ and go to SEND.
  - DONE:
    - att<=1, busy<=0.
    - ctrl_id<=id_tmp, buttons<={btn_hi, btn_lo}, frame_valid pulse in the same cycle.
    - Go to WAIT_PERIOD with the counter at 0.
  - Abort: att<=1, busy<=0, err pulse, err_code updated, ctrl_id/buttons unchanged, go to WAIT_PERIOD with the counter at 0.
- No ack is expected after byte 4; an ack there is ignored.
- enable is sampled only in IDLE and WAIT_PERIOD; a frame in flight always completes or aborts.
- xfer_done outside XFER is ignored.
- xfer_done and ack_seen in the same cycle: the ack is latched and the byte is processed; WAIT_ACK then exits on its first cycle.
- All counters saturate and never wrap; the WAIT_PERIOD counter width is 32 bits.
- At most one of frame_valid and err pulses per frame.

Test Plan:
- Good frame:
  - Stimulus: POLL_PERIOD=100, enable=1; model replies FF,73,5A,FE,FF with ack_n low 3 cycles, 20 cycles after each of bytes 0-3.
  - Response: att low after 100 cycles; xfer_tx sequence 01,42,00,00,00; frame_valid once; ctrl_id=73, buttons=FFFE; att high.
- Ack timeout:
  - Stimulus: as good frame, but no ack after byte 1.
  - Response: att rises ACK_TIMEOUT cycles after byte-1 xfer_done; err=1, err_code=01; buttons keeps its previous value; next frame starts POLL_PERIOD cycles later.
- Bad marker:
  - Stimulus: byte 2 returns 8'h00.
  - Response: abort on the byte-2 xfer_done cycle; err_code=10; no 4th xfer_start.
- Early ack:
  - Stimulus: ack_n pulse lands before xfer_done.
  - Response: frame completes normally; the GAP of INTER_BYTE cycles is still observed.
- Reset mid-byte:
  - Stimulus: rst_n low during XFER of byte 3.
  - Response: att=1 asynchronously; outputs at reset values; after release, a full POLL_PERIOD elapses before the next att low.
- Enable drop:
  - Stimulus: enable=0 during byte 2.
  - Response: frame completes with frame_valid; state returns to IDLE; no further att low while enable=0.

Source files
------------

// File: rtl/psx_poll_sequencer.sv
// psx_poll_sequencer: host-side frame scheduler for the PSX controller bus.
// Periodically lowers att, sends the 5-byte poll (01 42 00 00 00) through a
// byte-level transceiver, waits for ack_n between bytes and captures the
// controller ID and the 16-bit button word. Frames abort on a missing ack,
// a bad 0x5A marker or a transceiver stall.
//
// Ports:
//   clk, rst_n    system clock (rising edge), async active-low reset
//   enable        level; allows new frames to start
//   ack_n         controller ack, asynchronous, active low
//   xfer_start    one-cycle pulse; transceiver begins shifting xfer_tx
//   xfer_tx[7:0]  byte to send, valid on the xfer_start cycle
//   xfer_done     one-cycle pulse; xfer_rx valid this cycle
//   xfer_rx[7:0]  byte received from controller
//   att           attention, active low
//   ctrl_id[7:0]  last good ID byte
//   buttons[15:0] last good button word {byte4, byte3}, active low
//   frame_valid   one-cycle pulse after a good frame
//   err           one-cycle pulse on an aborted frame
//   err_code[1:0] 01 ack timeout, 10 bad marker, 11 stall; held until next err
//   busy          high from att low through att high
module psx_poll_sequencer #(
    parameter logic [31:0] POLL_PERIOD = 32'd33333,
    parameter logic [7:0]  ATT_SETUP   = 8'd40,
    parameter logic [15:0] ACK_TIMEOUT = 16'd200,
    parameter logic [7:0]  INTER_BYTE  = 8'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        ack_n,
    output logic        xfer_start,
    output logic [7:0]  xfer_tx,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx,
    output logic        att,
    output logic [7:0]  ctrl_id,
    output logic [15:0] buttons,
    output logic        frame_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned IDX_W = 3;

    // Terminal counts: each state exits on the cycle its counter holds *_LAST.
    localparam logic [CNT_W-1:0] PERIOD_LAST = POLL_PERIOD - 32'd1;
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(ATT_SETUP) - 32'd1;
    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT) - 32'd1;
    localparam logic [CNT_W-1:0] STALL_LAST  = (CNT_W'(ACK_TIMEOUT) << 2) - 32'd1;
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(INTER_BYTE) - 32'd1;

    localparam logic [7:0] MARKER = 8'h5A;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ACK    = 2'b01;
    localparam logic [1:0] ERR_MARKER = 2'b10;
    localparam logic [1:0] ERR_STALL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PERIOD,
        S_ATT_SETUP,
        S_SEND,
        S_XFER,
        S_WAIT_ACK,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [7:0]         id_tmp;
    logic [7:0]         btn_lo;
    logic [7:0]         btn_hi;
    logic [2:0]         ack_sync;
    logic               ack_seen;
    logic               ack_flag;
    logic               abort_c;
    logic [1:0]         abort_code_c;

    // Poll command bytes by index.
    function automatic logic [7:0] poll_byte(input logic [IDX_W-1:0] i);
        case (i)
            3'd0:    return 8'h01;
            3'd1:    return 8'h42;
            default: return 8'h00;
        endcase
    endfunction

    // Saturating shared counter; never wraps.
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 32'd1;
    assign idx_next = idx + 3'd1;

    // Two synchronizer flops plus one edge flop; ack_seen on a falling edge.
    assign ack_seen = ack_sync[2] & ~ack_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= 3'b111;
        end else begin
            ack_sync <= {ack_sync[1:0], ack_n};
        end
    end

    // Abort conditions for the current cycle.
    always_comb begin
        abort_c      = 1'b0;
        abort_code_c = ERR_NONE;
        case (state)
            S_XFER: begin
                if (xfer_done) begin
                    if (idx == 3'd2 && xfer_rx != MARKER) begin
                        abort_c      = 1'b1;
                        abort_code_c = ERR_MARKER;
                    end
                end else if (cnt >= STALL_LAST) begin
                    abort_c      = 1'b1;
                    abort_code_c = ERR_STALL;
                end
            end
            S_WAIT_ACK: begin
                if (!ack_flag && cnt >= ACK_LAST) begin
                    abort_c      = 1'b1;
                    abort_code_c = ERR_ACK;
                end
            end
            default: ;
        endcase
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            id_tmp      <= 8'hFF;
            btn_lo      <= 8'hFF;
            btn_hi      <= 8'hFF;
            ack_flag    <= 1'b0;
            att         <= 1'b1;
            busy        <= 1'b0;
            xfer_start  <= 1'b0;
            xfer_tx     <= 8'hFF;
            ctrl_id     <= 8'hFF;
            buttons     <= 16'hFFFF;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            xfer_start  <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            // Sticky so an ack arriving before xfer_done still counts.
            if (ack_seen) begin
                ack_flag <= 1'b1;
            end

            if (abort_c) begin
                att      <= 1'b1;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= abort_code_c;
                cnt      <= '0;
                state    <= S_WAIT_PERIOD;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (enable) begin
                            cnt   <= '0;
                            state <= S_WAIT_PERIOD;
                        end
                    end
                    S_WAIT_PERIOD: begin
                        if (!enable) begin
                            state <= S_IDLE;
                        end else if (cnt >= PERIOD_LAST) begin
                            att   <= 1'b0;
                            busy  <= 1'b1;
                            idx   <= '0;
                            cnt   <= '0;
                            state <= S_ATT_SETUP;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_ATT_SETUP: begin
                        if (cnt >= SETUP_LAST) begin
                            xfer_start <= 1'b1;
                            xfer_tx    <= poll_byte(idx);
                            cnt        <= '0;
                            state      <= S_SEND;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_SEND: begin
                        // xfer_start is high this cycle; restart ack tracking.
                        ack_flag <= 1'b0;
                        cnt      <= '0;
                        state    <= S_XFER;
                    end
                    S_XFER: begin
                        if (xfer_done) begin
                            case (idx)
                                3'd1:    id_tmp <= xfer_rx;
                                3'd3:    btn_lo <= xfer_rx;
                                3'd4:    btn_hi <= xfer_rx;
                                default: ;
                            endcase
                            cnt   <= '0;
                            state <= (idx == 3'd4) ? S_DONE : S_WAIT_ACK;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (ack_flag) begin
                            cnt   <= '0;
                            state <= S_GAP;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_GAP: begin
                        if (cnt >= GAP_LAST) begin
                            idx        <= idx_next;
                            xfer_start <= 1'b1;
                            xfer_tx    <= poll_byte(idx_next);
                            cnt        <= '0;
                            state      <= S_SEND;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_DONE: begin
                        att         <= 1'b1;
                        busy        <= 1'b0;
                        ctrl_id     <= id_tmp;
                        buttons     <= {btn_hi, btn_lo};
                        frame_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= S_WAIT_PERIOD;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psx_poll_sequencer.sv
// Testbench for psx_poll_sequencer: a behavioural transceiver/controller
// model answers each poll byte; a table of frame scenarios is run back to
// back, followed by hand-written reset-mid-byte and enable-drop sequences.
module tb_psx_poll_sequencer;

    localparam int P  = 100;
    localparam int T  = 200;
    localparam int IB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        ack_n;
    logic        xfer_start;
    logic [7:0]  xfer_tx;
    logic        xfer_done;
    logic [7:0]  xfer_rx;
    logic        att;
    logic [7:0]  ctrl_id;
    logic [15:0] buttons;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    psx_poll_sequencer #(.POLL_PERIOD(32'd100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ack_n(ack_n),
        .xfer_start(xfer_start), .xfer_tx(xfer_tx), .xfer_done(xfer_done),
        .xfer_rx(xfer_rx), .att(att), .ctrl_id(ctrl_id), .buttons(buttons),
        .frame_valid(frame_valid), .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string           name;
        logic [4:0][7:0] reply;      // reply[i] = byte returned for byte i
        int              noack;      // byte index with no ack (-1: none)
        bit              early;      // ack pulse lands before xfer_done
        int              stall;      // byte index never completed (-1: none)
        int              exp_nstart;
        int              exp_valid;
        int              exp_err;
        logic [1:0]      exp_code;
        logic [7:0]      exp_id;
        logic [15:0]     exp_btn;
        int              kind;       // extra timing check selector
    } vec_t;

    vec_t vecs[6];
    vec_t cur;

    logic [7:0] poll_tbl [5];
    logic [7:0] tx_log   [5];
    int         t_start  [5];
    int         t_done   [5];

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid, n_err, n_start;

    function automatic vec_t mk(input string nm, input logic [39:0] rep,
                                input int noack, input bit early, input int stall,
                                input int ns, input int nv, input int ne,
                                input logic [1:0] code, input logic [7:0] id,
                                input logic [15:0] btn, input int kind);
        vec_t r;
        r.name = nm; r.reply = rep; r.noack = noack; r.early = early;
        r.stall = stall; r.exp_nstart = ns; r.exp_valid = nv; r.exp_err = ne;
        r.exp_code = code; r.exp_id = id; r.exp_btn = btn; r.kind = kind;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_att(input logic val, input int budget, output int t);
        int k;
        k = 0;
        while (att !== val && k < budget) begin
            @(negedge clk);
            k++;
        end
        t = cyc;
        n_cmp++;
        if (att !== val) begin
            n_bad++;
            $display("FAIL wait_att_%0b: timed out after %0d cycles, att=%b required %b",
                     val, budget, att, val);
        end
    endtask

    // Controller + transceiver behaviour for one byte.
    task automatic serve_byte(input int bi);
        if (bi == cur.stall) return;
        if (cur.early && bi < 4) begin
            repeat (2) @(negedge clk);
            ack_n = 1'b0;
            repeat (3) @(negedge clk);
            ack_n = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
        xfer_rx   = cur.reply[bi];
        xfer_done = 1'b1;
        t_done[bi] = cyc;
        @(negedge clk);
        xfer_done = 1'b0;
        if (!cur.early && bi < 4 && bi != cur.noack) begin
            repeat (19) @(negedge clk);
            ack_n = 1'b0;
            repeat (3) @(negedge clk);
            ack_n = 1'b1;
        end
    endtask

    initial begin : xcvr
        int bi;
        bi = 0;
        forever begin
            @(negedge clk);
            if (att === 1'b1) bi = 0;
            if (xfer_start === 1'b1 && bi < 5) begin
                tx_log[bi]  = xfer_tx;
                t_start[bi] = cyc;
                serve_byte(bi);
                bi++;
            end
        end
    end

    initial begin : mon
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) n_valid++;
            if (err === 1'b1)         n_err++;
            if (xfer_start === 1'b1)  n_start++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t_ref, t_fall, t_rise, k, lows;

        poll_tbl[0] = 8'h01; poll_tbl[1] = 8'h42; poll_tbl[2] = 8'h00;
        poll_tbl[3] = 8'h00; poll_tbl[4] = 8'h00;

        //             name       reply {b4,b3,b2,b1,b0}                     noack early stall ns v  e  code   id     btn       kind
        vecs[0] = mk("good",     {8'hFF,8'hFE,8'h5A,8'h73,8'hFF}, -1, 1'b0, -1, 5, 1, 0, 2'b00, 8'h73, 16'hFFFE, 0);
        vecs[1] = mk("ack_to",   {8'h00,8'h00,8'h5A,8'h41,8'hFF},  1, 1'b0, -1, 2, 0, 1, 2'b01, 8'h73, 16'hFFFE, 1);
        vecs[2] = mk("marker",   {8'h00,8'h00,8'h00,8'h41,8'hFF}, -1, 1'b0, -1, 3, 0, 1, 2'b10, 8'h73, 16'hFFFE, 2);
        vecs[3] = mk("early",    {8'h34,8'h12,8'h5A,8'h79,8'hFF}, -1, 1'b1, -1, 5, 1, 0, 2'b10, 8'h79, 16'h3412, 3);
        vecs[4] = mk("stall",    {8'h00,8'h00,8'h5A,8'h41,8'hFF}, -1, 1'b0,  3, 4, 0, 1, 2'b11, 8'h79, 16'h3412, 4);
        vecs[5] = mk("good2",    {8'h55,8'hAA,8'h5A,8'h41,8'hFF}, -1, 1'b0, -1, 5, 1, 0, 2'b11, 8'h41, 16'h55AA, 0);

        rst_n = 1'b0; enable = 1'b0; ack_n = 1'b1; xfer_done = 1'b0; xfer_rx = 8'h00;
        cur = vecs[0];
        n_valid = 0; n_err = 0; n_start = 0;
        repeat (3) @(negedge clk);

        chk("rst_att",         32'(att),         32'h1);
        chk("rst_busy",        32'(busy),        32'h0);
        chk("rst_xfer_start",  32'(xfer_start),  32'h0);
        chk("rst_xfer_tx",     32'(xfer_tx),     32'hFF);
        chk("rst_ctrl_id",     32'(ctrl_id),     32'hFF);
        chk("rst_buttons",     32'(buttons),     32'hFFFF);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        chk("rst_err",         32'(err),         32'h0);
        chk("rst_err_code",    32'(err_code),    32'h0);

        enable = 1'b1;
        rst_n  = 1'b1;
        t_ref  = cyc;

        for (int v = 0; v < 6; v++) begin
            cur = vecs[v];
            n_valid = 0; n_err = 0; n_start = 0;
            wait_att(1'b0, 400, t_fall);
            chk({cur.name, "_period"}, 32'(t_fall - t_ref), (v == 0) ? 32'(P + 1) : 32'(P));
            chk({cur.name, "_busy_hi"}, 32'(busy), 32'h1);
            wait_att(1'b1, 4000, t_rise);
            repeat (2) @(negedge clk);
            chk({cur.name, "_nstart"}, 32'(n_start), 32'(cur.exp_nstart));
            for (int i = 0; i < cur.exp_nstart; i++)
                chk($sformatf("%s_tx%0d", cur.name, i), 32'(tx_log[i]), 32'(poll_tbl[i]));
            chk({cur.name, "_valid"},    32'(n_valid),  32'(cur.exp_valid));
            chk({cur.name, "_err"},      32'(n_err),    32'(cur.exp_err));
            chk({cur.name, "_err_code"}, 32'(err_code), 32'(cur.exp_code));
            chk({cur.name, "_ctrl_id"},  32'(ctrl_id),  32'(cur.exp_id));
            chk({cur.name, "_buttons"},  32'(buttons),  32'(cur.exp_btn));
            chk({cur.name, "_busy_lo"},  32'(busy),     32'h0);
            case (cur.kind)
                1: chk("ack_to_latency", 32'(t_rise - t_done[1]), 32'(T + 1));
                2: chk("marker_latency", 32'(t_rise - t_done[2]), 32'h1);
                3: begin
                    chk("early_gap01", 32'(t_start[1] - t_done[0]), 32'(IB + 2));
                    chk("early_gap23", 32'(t_start[3] - t_done[2]), 32'(IB + 2));
                end
                4: chk("stall_latency", 32'(t_rise - t_start[3]), 32'(4 * T + 1));
                default: ;
            endcase
            t_ref = t_rise;
        end

        // Reset during XFER of byte 3: att must rise without a clock edge.
        cur = vecs[0];
        n_valid = 0; n_err = 0; n_start = 0;
        wait_att(1'b0, 400, t_fall);
        k = 0;
        while (n_start < 4 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_reached_byte3", 32'(n_start), 32'h4);
        repeat (3) @(negedge clk);
        chk("midrst_att_before", 32'(att), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_att_async",   32'(att),        32'h1);
        chk("midrst_busy",        32'(busy),       32'h0);
        chk("midrst_ctrl_id",     32'(ctrl_id),    32'hFF);
        chk("midrst_buttons",     32'(buttons),    32'hFFFF);
        chk("midrst_err_code",    32'(err_code),   32'h0);
        chk("midrst_xfer_tx",     32'(xfer_tx),    32'hFF);
        repeat (3) @(negedge clk);
        cur = vecs[5];
        n_valid = 0; n_err = 0; n_start = 0;
        rst_n = 1'b1;
        t_ref = cyc;

        // Enable drops during byte 2: the frame still completes, then idle.
        wait_att(1'b0, 400, t_fall);
        chk("midrst_period", 32'(t_fall - t_ref), 32'(P + 1));
        k = 0;
        while (n_start < 3 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        wait_att(1'b1, 4000, t_rise);
        repeat (2) @(negedge clk);
        chk("endrop_valid",   32'(n_valid), 32'h1);
        chk("endrop_err",     32'(n_err),   32'h0);
        chk("endrop_ctrl_id", 32'(ctrl_id), 32'h41);
        chk("endrop_buttons", 32'(buttons), 32'h55AA);
        lows = 0;
        repeat (3 * P) begin
            @(negedge clk);
            if (att !== 1'b1) lows++;
        end
        chk("endrop_no_att_low", 32'(lows),    32'h0);
        chk("endrop_nstart",     32'(n_start), 32'h5);
        chk("endrop_busy",       32'(busy),    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
